int_ctrl: RTL and testbench
===========================

// Module: int_ctrl
// PURPOSE
//  Interrupt controller between the memory-mapped IO modules and the CPU core.
//  Collects per-module normal (intr) and fast (fintr) request levels, arbitrates, and presents one
//  request plus vector to the CPU. On CPU acceptance it pulses int_ack back to the winning module.
//  It drives that module's Enable for the duration of its ISR. Allows one level of nesting: fast preempts normal.
// PARAMETERS
//  NUM_SRC  4               number of IO modules (request/ack/enable lanes)
//  IDX_W    $clog2(NUM_SRC) width of source index in int_vec
// PORTS
//  Clk        in   1        system clock, all logic on posedge
//  Reset      in   1        synchronous, active-high reset
//  intr_req   in   NUM_SRC  normal request levels (IO intr_check)
//  fintr_req  in   NUM_SRC  fast request levels (IO fintr_check)
//  int_en     in   1        global interrupt enable from CPU; gates new arbitration only
//  cpu_ack    in   1        CPU accepts presented request (1-cycle pulse)
//  cpu_iret   in   1        CPU returns from current ISR (1-cycle pulse)
//  cpu_intr   out  1        normal request to CPU
//  cpu_fintr  out  1        fast request to CPU
//  int_vec    out  IDX_W    index of presented/serviced source
//  int_ack    out  NUM_SRC  one-hot 1-cycle acknowledge to IO module
//  io_enable  out  NUM_SRC  one-hot-or-zero Enable to IO modules during ISR
// BEHAVIOUR
//  - Reset: state IDLE; cpu_intr=cpu_fintr=0, int_vec=0, int_ack=0, io_enable=0, saved index=0.
//    Reset mid-operation aborts any ISR tracking the same way.
//  - Arbitration: any fintr_req beats any intr_req; within a class, lowest index wins.
//  - States: IDLE, REQ_N, SVC_N, REQ_FN (fast pending over normal ISR), REQ_F, SVC_F, SVC_FN.
//  - IDLE: if int_en and any request -> REQ_F (fast) or REQ_N. Winner index is latched into int_vec.
//    cpu_fintr/cpu_intr=1 in the next cycle (latency 1).
//  - REQ_x: request and int_vec are held even if the source drops its level.
//    On cpu_ack -> SVC_x next cycle. In that cycle int_ack[int_vec]=1 for exactly 1 cycle,
//    io_enable[int_vec]=1, and cpu_intr/cpu_fintr=0.
//  - SVC_N: if int_en and any fintr_req -> REQ_FN. The normal index is saved, cpu_fintr=1, and
//    int_vec = fast winner. io_enable of the normal source stays 1 until the fast ack.
//  - REQ_FN: on cpu_ack -> SVC_FN. Pulse int_ack[fast]; io_enable moves to the fast source.
//    On cpu_iret (normal ISR ended first) -> REQ_F; io_enable=0 and the fast request is still presented.
//  - SVC_F: on cpu_iret -> IDLE, io_enable=0.
//  - SVC_FN: on cpu_iret -> SVC_N. int_vec and io_enable are restored to the saved normal index.
//  - cpu_ack outside REQ_* and cpu_iret in IDLE/REQ_N/REQ_F are ignored.
//  - cpu_ack and cpu_iret in the same cycle: ack wins, iret ignored.
//  - Nested normal requests are never taken; max nesting depth is 2.
//  - Returning to IDLE re-samples levels: a source re-asserting immediately after its ack is serviced again.
//  - Invariants: popcount(io_enable)<=1; popcount(int_ack)<=1; cpu_intr & cpu_fintr never both 1.
//  - int_en low does not cancel a request already in REQ_* nor end an ISR.
// STRUCTURE
//  - int_ctrl_defs.vh: state encodings (3-bit localparams), NUM_SRC default.
//  - Sub-module prio_enc (NUM_SRC-in lowest-index-first encoder, outputs valid + index).
//    Instantiated twice, once for fintr_req and once for intr_req.
//  - Top: state register, latched int_vec, saved normal index, registered outputs.
// TESTING  (NUM_SRC=4)
//  1 intr_req=4'b0100, int_en=1 -> next cycle cpu_intr=1, int_vec=2.
//    cpu_ack -> int_ack=4'b0100 for 1 cycle, io_enable=4'b0100.
//    cpu_iret -> io_enable=0, IDLE.
//  2 intr_req=4'b1010, fintr_req=4'b1000 same cycle -> cpu_fintr=1, int_vec=3.
//    After its ISR, cpu_intr=1, int_vec=1.
//  3 In SVC_N (idx 0) raise fintr_req[2] -> cpu_fintr=1, int_vec=2, io_enable=0001.
//    ack -> io_enable=0100, int_ack=0100.
//    iret -> io_enable=0001, int_vec=0. iret -> IDLE.
//  4 REQ_N idx1, source drops intr_req before ack -> cpu_intr stays 1, int_vec=1.
//    Same-cycle ack+iret -> treated as ack only.
//  5 int_en=0 with intr_req=4'b0001 -> no cpu_intr; int_en=1 -> cpu_intr next cycle.
//    Reset in SVC_FN -> all outputs 0 next cycle.
//  6 Source re-raises intr_req in the same cycle as its int_ack pulse (IO handshake pattern) ->
//    serviced again after iret; the one-hot invariants are checked every cycle.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// ============================================================================
// Module  : int_ctrl_pkg
// Brief   : Shared state encoding and defaults for the interrupt controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package int_ctrl_pkg;

  localparam int c_NUM_SRC_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_N  = 3'd1,
    ST_SVC_N  = 3'd2,
    ST_REQ_FN = 3'd3,
    ST_REQ_F  = 3'd4,
    ST_SVC_F  = 3'd5,
    ST_SVC_FN = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/int_ctrl_prio_enc.sv
// ============================================================================
// Module  : int_ctrl_prio_enc
// Brief   : Lowest-index-first priority encoder with valid flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctrl_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  assign o_valid = |i_req;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
// Module  : int_ctrl
// Brief   : Two-class interrupt controller with one level of fast-over-normal nesting.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = c_NUM_SRC_DEFAULT,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] intr_req,
  input  logic [NUM_SRC-1:0] fintr_req,
  input  logic               int_en,
  input  logic               cpu_ack,
  input  logic               cpu_iret,
  output logic               cpu_intr,
  output logic               cpu_fintr,
  output logic [IDX_W-1:0]   int_vec,
  output logic [NUM_SRC-1:0] int_ack,
  output logic [NUM_SRC-1:0] io_enable
);

  state_t               r_state, w_next;
  logic [IDX_W-1:0]     r_vec, w_vec_d;
  logic [IDX_W-1:0]     r_saved, w_saved_d;
  logic [NUM_SRC-1:0]   r_ack, w_ack_d;

  logic                 w_f_valid, w_n_valid;
  logic [IDX_W-1:0]     w_f_idx, w_n_idx;
  logic [NUM_SRC-1:0]   w_vec_oh, w_saved_oh;

  int_ctrl_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_enc_fast (
    .i_req   (fintr_req),
    .o_valid (w_f_valid),
    .o_idx   (w_f_idx)
  );

  int_ctrl_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_enc_norm (
    .i_req   (intr_req),
    .o_valid (w_n_valid),
    .o_idx   (w_n_idx)
  );

  assign w_vec_oh   = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_vec;
  assign w_saved_oh = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_saved;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_saved <= '0;
      r_ack   <= '0;
    end else begin
      r_state <= w_next;
      r_vec   <= w_vec_d;
      r_saved <= w_saved_d;
      r_ack   <= w_ack_d;
    end
  end

  // cpu_ack is only meaningful in REQ_*; checking it first there makes ack win over iret.
  always_comb begin
    w_next    = r_state;
    w_vec_d   = r_vec;
    w_saved_d = r_saved;
    w_ack_d   = '0;
    case (r_state)
      ST_IDLE: begin
        if (int_en && w_f_valid) begin
          w_next  = ST_REQ_F;
          w_vec_d = w_f_idx;
        end else if (int_en && w_n_valid) begin
          w_next  = ST_REQ_N;
          w_vec_d = w_n_idx;
        end
      end
      ST_REQ_N: begin
        if (cpu_ack) begin
          w_next  = ST_SVC_N;
          w_ack_d = w_vec_oh;
        end
      end
      ST_REQ_F: begin
        if (cpu_ack) begin
          w_next  = ST_SVC_F;
          w_ack_d = w_vec_oh;
        end
      end
      ST_SVC_N: begin
        if (cpu_iret) begin
          w_next = ST_IDLE;
        end else if (int_en && w_f_valid) begin
          w_next    = ST_REQ_FN;
          w_saved_d = r_vec;
          w_vec_d   = w_f_idx;
        end
      end
      ST_REQ_FN: begin
        if (cpu_ack) begin
          w_next  = ST_SVC_FN;
          w_ack_d = w_vec_oh;
        end else if (cpu_iret) begin
          w_next = ST_REQ_F;
        end
      end
      ST_SVC_F: begin
        if (cpu_iret) w_next = ST_IDLE;
      end
      ST_SVC_FN: begin
        if (cpu_iret) begin
          w_next  = ST_SVC_N;
          w_vec_d = r_saved;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // While the fast request waits over a normal ISR, the normal source keeps its enable.
  always_comb begin
    io_enable = '0;
    case (r_state)
      ST_SVC_N, ST_SVC_F, ST_SVC_FN: io_enable = w_vec_oh;
      ST_REQ_FN:                     io_enable = w_saved_oh;
      default:                       io_enable = '0;
    endcase
  end

  assign cpu_intr  = (r_state == ST_REQ_N);
  assign cpu_fintr = (r_state == ST_REQ_F) || (r_state == ST_REQ_FN);
  assign int_vec   = r_vec;
  assign int_ack   = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
// Module  : tb_int_ctrl
// Brief   : Directed vector table plus hand sequences for int_ctrl (NUM_SRC=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] intr_req, fintr_req;
  logic       int_en, cpu_ack, cpu_iret;
  logic       cpu_intr, cpu_fintr;
  logic [1:0] int_vec;
  logic [3:0] int_ack, io_enable;

  int n_asserts = 0;
  int n_fail    = 0;
  bit inv_on    = 1'b0;

  always #5 Clk = ~Clk;

  int_ctrl #(.NUM_SRC(4), .IDX_W(2)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .intr_req  (intr_req),
    .fintr_req (fintr_req),
    .int_en    (int_en),
    .cpu_ack   (cpu_ack),
    .cpu_iret  (cpu_iret),
    .cpu_intr  (cpu_intr),
    .cpu_fintr (cpu_fintr),
    .int_vec   (int_vec),
    .int_ack   (int_ack),
    .io_enable (io_enable)
  );

  typedef struct {
    logic       rst, en;
    logic [3:0] intr, fintr;
    logic       ack, iret;
    logic       e_ci, e_cf;
    logic [1:0] e_vec;
    logic [3:0] e_ack, e_en;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic [3:0] intr, input logic [3:0] fintr,
                     input logic ack, input logic iret, input logic ci, input logic cf,
                     input logic [1:0] vec, input logic [3:0] iack, input logic [3:0] ien);
    vec_t v;
    v.rst = rst; v.en = en; v.intr = intr; v.fintr = fintr; v.ack = ack; v.iret = iret;
    v.e_ci = ci; v.e_cf = cf; v.e_vec = vec; v.e_ack = iack; v.e_en = ien;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic en, input logic [3:0] intr, input logic [3:0] fintr,
                       input logic ack, input logic iret);
    Reset = rst; int_en = en; intr_req = intr; fintr_req = fintr; cpu_ack = ack; cpu_iret = iret;
  endtask

  // One-hot and exclusivity invariants, sampled every cycle once out of reset.
  always @(negedge Clk) begin
    if (inv_on && !Reset) begin
      check("inv_io_enable_onehot", 32'($countones(io_enable) <= 1), 32'd1);
      check("inv_int_ack_onehot",   32'($countones(int_ack) <= 1),   32'd1);
      check("inv_intr_fintr_excl",  32'(cpu_intr & cpu_fintr),       32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    drive(1, 0, 4'b0, 4'b0, 0, 0);

    //   rst en intr     fintr    ack iret  ci cf vec   iack     ien
    add(1, 0, 4'b0000, 4'b0000, 0, 0,   0, 0, 2'd0, 4'b0000, 4'b0000); // reset state
    // single normal request, ack, iret
    add(0, 1, 4'b0100, 4'b0000, 0, 0,   1, 0, 2'd2, 4'b0000, 4'b0000);
    add(0, 1, 4'b0000, 4'b0000, 1, 0,   0, 0, 2'd2, 4'b0100, 4'b0100);
    add(0, 1, 4'b0000, 4'b0000, 0, 0,   0, 0, 2'd2, 4'b0000, 4'b0100);
    add(0, 1, 4'b0000, 4'b0000, 0, 1,   0, 0, 2'd2, 4'b0000, 4'b0000);
    // fast beats normal, then normal serviced after
    add(0, 1, 4'b1010, 4'b1000, 0, 0,   0, 1, 2'd3, 4'b0000, 4'b0000);
    add(0, 1, 4'b1010, 4'b0000, 1, 0,   0, 0, 2'd3, 4'b1000, 4'b1000);
    add(0, 1, 4'b1010, 4'b0000, 0, 1,   0, 0, 2'd3, 4'b0000, 4'b0000);
    add(0, 1, 4'b1010, 4'b0000, 0, 0,   1, 0, 2'd1, 4'b0000, 4'b0000);
    add(0, 1, 4'b0000, 4'b0000, 1, 0,   0, 0, 2'd1, 4'b0010, 4'b0010);
    add(0, 1, 4'b0000, 4'b0000, 0, 1,   0, 0, 2'd1, 4'b0000, 4'b0000);
    // fast nests over normal ISR, returns to normal
    add(0, 1, 4'b0001, 4'b0000, 0, 0,   1, 0, 2'd0, 4'b0000, 4'b0000);
    add(0, 1, 4'b0000, 4'b0000, 1, 0,   0, 0, 2'd0, 4'b0001, 4'b0001);
    add(0, 1, 4'b0000, 4'b0100, 0, 0,   0, 1, 2'd2, 4'b0000, 4'b0001);
    add(0, 1, 4'b0000, 4'b0000, 1, 0,   0, 0, 2'd2, 4'b0100, 4'b0100);
    add(0, 1, 4'b0000, 4'b0000, 0, 1,   0, 0, 2'd0, 4'b0000, 4'b0001);
    add(0, 1, 4'b0000, 4'b0000, 0, 1,   0, 0, 2'd0, 4'b0000, 4'b0000);
    // request held after source drops; ack+iret treated as ack
    add(0, 1, 4'b0010, 4'b0000, 0, 0,   1, 0, 2'd1, 4'b0000, 4'b0000);
    add(0, 1, 4'b0000, 4'b0000, 0, 0,   1, 0, 2'd1, 4'b0000, 4'b0000);
    add(0, 1, 4'b0000, 4'b0000, 1, 1,   0, 0, 2'd1, 4'b0010, 4'b0010);
    add(0, 1, 4'b0000, 4'b0000, 0, 0,   0, 0, 2'd1, 4'b0000, 4'b0010);
    add(0, 1, 4'b0000, 4'b0000, 0, 1,   0, 0, 2'd1, 4'b0000, 4'b0000);
    // normal ISR ends while fast pending -> fast still presented
    add(0, 1, 4'b0001, 4'b0000, 0, 0,   1, 0, 2'd0, 4'b0000, 4'b0000);
    add(0, 1, 4'b0000, 4'b0000, 1, 0,   0, 0, 2'd0, 4'b0001, 4'b0001);
    add(0, 1, 4'b0000, 4'b1000, 0, 0,   0, 1, 2'd3, 4'b0000, 4'b0001);
    add(0, 1, 4'b0000, 4'b0000, 0, 1,   0, 1, 2'd3, 4'b0000, 4'b0000);
    add(0, 1, 4'b0000, 4'b0000, 1, 0,   0, 0, 2'd3, 4'b1000, 4'b1000);
    add(0, 1, 4'b0000, 4'b0000, 0, 1,   0, 0, 2'd3, 4'b0000, 4'b0000);
    // int_en gating; int_en low does not cancel pending/active
    add(0, 0, 4'b0001, 4'b0000, 0, 0,   0, 0, 2'd3, 4'b0000, 4'b0000);
    add(0, 0, 4'b0001, 4'b0000, 0, 0,   0, 0, 2'd3, 4'b0000, 4'b0000);
    add(0, 1, 4'b0001, 4'b0000, 0, 0,   1, 0, 2'd0, 4'b0000, 4'b0000);
    add(0, 0, 4'b0000, 4'b0000, 0, 0,   1, 0, 2'd0, 4'b0000, 4'b0000);
    add(0, 0, 4'b0000, 4'b0000, 1, 0,   0, 0, 2'd0, 4'b0001, 4'b0001);
    add(0, 0, 4'b0000, 4'b0010, 0, 0,   0, 0, 2'd0, 4'b0000, 4'b0001);
    add(0, 1, 4'b0000, 4'b0010, 0, 0,   0, 1, 2'd1, 4'b0000, 4'b0001);
    add(0, 1, 4'b0000, 4'b0000, 1, 0,   0, 0, 2'd1, 4'b0010, 4'b0010);
    // reset inside SVC_FN, then stray ack in IDLE
    add(1, 1, 4'b0000, 4'b0000, 0, 0,   0, 0, 2'd0, 4'b0000, 4'b0000);
    add(0, 1, 4'b0000, 4'b0000, 0, 0,   0, 0, 2'd0, 4'b0000, 4'b0000);
    add(0, 1, 4'b0000, 4'b0000, 1, 0,   0, 0, 2'd0, 4'b0000, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge Clk);
      drive(tbl[i].rst, tbl[i].en, tbl[i].intr, tbl[i].fintr, tbl[i].ack, tbl[i].iret);
      @(posedge Clk);
      #1;
      inv_on = 1'b1;
      check($sformatf("row%0d cpu_intr", i),  32'(cpu_intr),  32'(tbl[i].e_ci));
      check($sformatf("row%0d cpu_fintr", i), 32'(cpu_fintr), 32'(tbl[i].e_cf));
      check($sformatf("row%0d int_vec", i),   32'(int_vec),   32'(tbl[i].e_vec));
      check($sformatf("row%0d int_ack", i),   32'(int_ack),   32'(tbl[i].e_ack));
      check($sformatf("row%0d io_enable", i), 32'(io_enable), 32'(tbl[i].e_en));
    end

    // Source keeps its level through its own ack: serviced again after iret.
    @(negedge Clk);
    drive(0, 1, 4'b0100, 4'b0000, 0, 0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk);
      #1;
      if (cpu_intr) begin
        seen = 1'b1;
        break;
      end
    end
    check("reraise first cpu_intr seen", 32'(seen), 32'd1);
    check("reraise first int_vec", 32'(int_vec), 32'd2);
    @(negedge Clk); cpu_ack = 1'b1;
    @(posedge Clk); #1;
    check("reraise int_ack pulse", 32'(int_ack), 32'h4);
    check("reraise io_enable", 32'(io_enable), 32'h4);
    @(negedge Clk); cpu_ack = 1'b0;
    @(posedge Clk); #1;
    check("reraise int_ack one cycle", 32'(int_ack), 32'h0);
    check("reraise no nested normal", 32'(cpu_intr), 32'd0);
    check("reraise io_enable held", 32'(io_enable), 32'h4);
    @(negedge Clk); cpu_iret = 1'b1;
    @(posedge Clk); #1;
    check("reraise iret io_enable", 32'(io_enable), 32'h0);
    check("reraise iret cpu_intr", 32'(cpu_intr), 32'd0);
    @(negedge Clk); cpu_iret = 1'b0;
    @(posedge Clk); #1;
    check("reraise second cpu_intr", 32'(cpu_intr), 32'd1);
    check("reraise second int_vec", 32'(int_vec), 32'd2);
    @(negedge Clk); drive(0, 1, 4'b0000, 4'b0000, 1, 0);
    @(negedge Clk); drive(0, 1, 4'b0000, 4'b0000, 0, 1);
    @(negedge Clk); drive(0, 1, 4'b0000, 4'b0000, 0, 0);
    @(posedge Clk); #1;
    check("final idle io_enable", 32'(io_enable), 32'h0);
    check("final idle cpu_intr", 32'(cpu_intr), 32'd0);

    inv_on = 1'b0;
    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
